fifo_wr_arbiter: RTL and testbench

Round-robin write arbiter that shares the write port of one syn_fifo among NUM_REQ requesters. Each requester uses a valid/ready handshake. The arbiter grants one requester at a time for bursts of up to BURST_LEN beats, and drives the FIFO's wr_en and data_in. It honours the FIFO's full flag, so the FIFO never sees a write while full.

---
 rtl/fifo_wr_arbiter.sv | 120 ++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter that shares one FIFO write port among NUM_REQ
// valid/ready requesters, granting bursts of up to BURST_LEN beats.
module fifo_wr_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ    = 4,
  parameter int BURST_LEN  = 4,
  parameter int CNT_WIDTH  = 3
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          fifo_full,
  output logic                          fifo_wr_en,
  output logic [DATA_WIDTH-1:0]         fifo_data_in,
  output logic [NUM_REQ-1:0]            gnt,
  output logic                          busy
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [CNT_WIDTH-1:0] LAST_BEAT = CNT_WIDTH'(BURST_LEN - 1);
  localparam logic [IDX_W-1:0]     LAST_IDX  = IDX_W'(NUM_REQ - 1);
  localparam logic [NUM_REQ-1:0]   ONE_HOT0  = NUM_REQ'(1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t                 state_reg;
  logic [NUM_REQ-1:0]     gnt_reg;
  logic [IDX_W-1:0]       gidx_reg;
  logic [IDX_W-1:0]       rr_ptr_reg;
  logic [CNT_WIDTH-1:0]   beat_cnt_reg;

  logic [DATA_WIDTH-1:0]  req_word [NUM_REQ];
  logic                   in_grant;
  logic                   g_valid;
  logic                   beat;
  logic                   release_grant;
  logic [IDX_W-1:0]       ptr_after_g;
  logic [IDX_W-1:0]       arb_ptr;
  logic                   win_found_next;
  logic [IDX_W-1:0]       win_idx_next;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
      assign req_word[gi]  = req_data[gi*DATA_WIDTH +: DATA_WIDTH];
      assign req_ready[gi] = in_grant & gnt_reg[gi] & ~fifo_full;
    end
  endgenerate

  assign in_grant      = (state_reg == GRANT);
  assign g_valid       = req_valid[gidx_reg];
  assign beat          = in_grant & g_valid & ~fifo_full;
  // A full-blocked final beat does not release; only a real beat or a dropped valid does.
  assign release_grant = in_grant & (~g_valid | (beat & (beat_cnt_reg == LAST_BEAT)));
  assign ptr_after_g   = (gidx_reg == LAST_IDX) ? '0 : gidx_reg + IDX_W'(1);
  assign arb_ptr       = in_grant ? ptr_after_g : rr_ptr_reg;

  always_comb begin
    logic [IDX_W-1:0] scan_idx;
    win_found_next = 1'b0;
    win_idx_next   = '0;
    scan_idx       = arb_ptr;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!win_found_next && req_valid[scan_idx]) begin
        win_found_next = 1'b1;
        win_idx_next   = scan_idx;
      end
      scan_idx = (scan_idx == LAST_IDX) ? '0 : scan_idx + IDX_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      gnt_reg      <= '0;
      gidx_reg     <= '0;
      rr_ptr_reg   <= '0;
      beat_cnt_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (win_found_next) begin
            state_reg    <= GRANT;
            gnt_reg      <= ONE_HOT0 << win_idx_next;
            gidx_reg     <= win_idx_next;
            beat_cnt_reg <= '0;
          end
        end
        GRANT: begin
          if (release_grant) begin
            rr_ptr_reg   <= ptr_after_g;
            beat_cnt_reg <= '0;
            // Back-to-back handover: the next winner is loaded without an idle cycle.
            if (win_found_next) begin
              gnt_reg  <= ONE_HOT0 << win_idx_next;
              gidx_reg <= win_idx_next;
            end else begin
              state_reg <= IDLE;
              gnt_reg   <= '0;
            end
          end else if (beat) begin
            beat_cnt_reg <= beat_cnt_reg + CNT_WIDTH'(1);
          end
        end
        default: begin
          state_reg <= IDLE;
          gnt_reg   <= '0;
        end
      endcase
    end
  end

  assign gnt          = gnt_reg;
  assign busy         = in_grant;
  assign fifo_wr_en   = beat;
  assign fifo_data_in = in_grant ? req_word[gidx_reg] : '0;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: per-cycle vector table plus hand
// sequences for full stalls, valid drops, mid-burst reset and a 16-deep FIFO.
module tb_fifo_wr_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic        fifo_full;
  logic        fifo_wr_en;
  logic [7:0]  fifo_data_in;
  logic [3:0]  gnt;
  logic        busy;

  logic        full_drv;
  logic        use_model;
  logic        model_clr;
  logic [7:0]  model_mem [16];
  logic [3:0]  model_wptr;
  logic [4:0]  model_count;
  logic        model_full;
  int          viol_cnt;

  int pass_cnt;
  int total_cnt;

  typedef struct {
    logic [3:0]  valid;
    logic [31:0] data;
    logic        full;
    logic [3:0]  e_gnt;
    logic        e_wr;
    logic [7:0]  e_din;
    logic [3:0]  e_rdy;
    logic        e_busy;
  } vec_t;

  vec_t vq[$];

  fifo_wr_arbiter #(
    .DATA_WIDTH(8), .NUM_REQ(4), .BURST_LEN(4), .CNT_WIDTH(3)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .fifo_full(fifo_full), .fifo_wr_en(fifo_wr_en),
    .fifo_data_in(fifo_data_in), .gnt(gnt), .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural 16-deep FIFO standing in for syn_fifo (write side only).
  assign model_full = (model_count == 5'd16);
  assign fifo_full  = use_model ? model_full : full_drv;

  always @(posedge clk) begin
    if (model_clr) begin
      model_wptr  <= '0;
      model_count <= '0;
    end else if (fifo_wr_en && !model_full) begin
      model_mem[model_wptr] <= fifo_data_in;
      model_wptr            <= model_wptr + 4'd1;
      model_count           <= model_count + 5'd1;
    end
  end

  initial viol_cnt = 0;
  always @(posedge clk) begin
    if (fifo_wr_en && fifo_full) viol_cnt <= viol_cnt + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic expect_out(input string tag, input logic [3:0] g, input logic w,
                            input logic [7:0] d, input logic [3:0] r, input logic b);
    check({tag, "_gnt"},  32'(gnt), 32'(g));
    check({tag, "_wr"},   32'(fifo_wr_en), 32'(w));
    check({tag, "_din"},  32'(fifo_data_in), 32'(d));
    check({tag, "_rdy"},  32'(req_ready), 32'(r));
    check({tag, "_busy"}, 32'(busy), 32'(b));
  endtask

  task automatic add_vec(input logic [3:0] v, input logic [31:0] dat, input logic f,
                         input logic [3:0] eg, input logic ew, input logic [7:0] ed,
                         input logic [3:0] er, input logic eb);
    vec_t t;
    t.valid = v; t.data = dat; t.full = f;
    t.e_gnt = eg; t.e_wr = ew; t.e_din = ed; t.e_rdy = er; t.e_busy = eb;
    vq.push_back(t);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; req_valid = '0; req_data = '0; full_drv = 1'b0;
    use_model = 1'b0; model_clr = 1'b1;
    @(negedge clk);
    rst_n = 1'b1; model_clr = 1'b0;
  endtask

  initial begin
    int i0, i2, acc;
    logic hs0, hs2;
    logic [7:0] exp_word;

    pass_cnt = 0; total_cnt = 0;
    rst_n = 1'b0; req_valid = '0; req_data = '0; full_drv = 1'b0;
    use_model = 1'b0; model_clr = 1'b1;

    // Single requester with a burst boundary, then a full-stalled burst
    // (including full on the final beat) handing over to req3.
    add_vec(4'b0010, 32'h0000_1000, 0, 4'b0000, 0, 8'h00, 4'b0000, 0);
    add_vec(4'b0010, 32'h0000_1000, 0, 4'b0010, 1, 8'h10, 4'b0010, 1);
    add_vec(4'b0010, 32'h0000_1100, 0, 4'b0010, 1, 8'h11, 4'b0010, 1);
    add_vec(4'b0010, 32'h0000_1200, 0, 4'b0010, 1, 8'h12, 4'b0010, 1);
    add_vec(4'b0010, 32'h0000_1300, 0, 4'b0010, 1, 8'h13, 4'b0010, 1);
    add_vec(4'b0010, 32'h0000_1400, 0, 4'b0010, 1, 8'h14, 4'b0010, 1);
    add_vec(4'b0010, 32'h0000_1500, 0, 4'b0010, 1, 8'h15, 4'b0010, 1);
    add_vec(4'b0000, 32'h0000_0000, 0, 4'b0010, 0, 8'h00, 4'b0010, 1);
    add_vec(4'b0000, 32'h0000_0000, 0, 4'b0000, 0, 8'h00, 4'b0000, 0);
    add_vec(4'b1100, 32'h3020_0000, 0, 4'b0000, 0, 8'h00, 4'b0000, 0);
    add_vec(4'b1100, 32'h3020_0000, 0, 4'b0100, 1, 8'h20, 4'b0100, 1);
    add_vec(4'b1100, 32'h3021_0000, 0, 4'b0100, 1, 8'h21, 4'b0100, 1);
    add_vec(4'b1100, 32'h3022_0000, 1, 4'b0100, 0, 8'h22, 4'b0000, 1);
    add_vec(4'b1100, 32'h3022_0000, 1, 4'b0100, 0, 8'h22, 4'b0000, 1);
    add_vec(4'b1100, 32'h3022_0000, 1, 4'b0100, 0, 8'h22, 4'b0000, 1);
    add_vec(4'b1100, 32'h3022_0000, 0, 4'b0100, 1, 8'h22, 4'b0100, 1);
    add_vec(4'b1100, 32'h3023_0000, 1, 4'b0100, 0, 8'h23, 4'b0000, 1);
    add_vec(4'b1100, 32'h3023_0000, 0, 4'b0100, 1, 8'h23, 4'b0100, 1);
    add_vec(4'b1000, 32'h3000_0000, 0, 4'b1000, 1, 8'h30, 4'b1000, 1);
    add_vec(4'b0000, 32'h0000_0000, 0, 4'b1000, 0, 8'h00, 4'b1000, 1);
    add_vec(4'b0000, 32'h0000_0000, 0, 4'b0000, 0, 8'h00, 4'b0000, 0);

    repeat (2) @(negedge clk);
    req_valid = 4'b1111;
    #1 expect_out("reset", 4'b0000, 0, 8'h00, 4'b0000, 0);
    @(negedge clk);
    rst_n = 1'b1; model_clr = 1'b0; req_valid = '0;

    for (int i = 0; i < vq.size(); i++) begin
      @(negedge clk);
      req_valid = vq[i].valid; req_data = vq[i].data; full_drv = vq[i].full;
      #1;
      expect_out($sformatf("vec%0d", i), vq[i].e_gnt, vq[i].e_wr, vq[i].e_din,
                 vq[i].e_rdy, vq[i].e_busy);
    end

    // All four requesters valid into an empty 16-deep FIFO.
    do_reset();
    use_model = 1'b1;
    @(negedge clk);
    req_valid = 4'b1111; req_data = 32'hA3A2_A1A0;
    #1 expect_out("t2_idle", 4'b0000, 0, 8'h00, 4'b0000, 0);
    for (int k = 0; k < 16; k++) begin
      @(negedge clk); #1;
      check($sformatf("t2_wr%0d", k),   32'(fifo_wr_en), 32'd1);
      check($sformatf("t2_din%0d", k),  32'(fifo_data_in), 32'h0A0 + 32'(k / 4));
      check($sformatf("t2_gnt%0d", k),  32'(gnt), 32'd1 << (k / 4));
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); #1;
      expect_out($sformatf("t2_full%0d", k), 4'b0001, 0, 8'hA0, 4'b0000, 1);
    end
    check("t2_count", 32'(model_count), 32'd16);
    check("t2_fullflag", 32'(model_full), 32'd1);

    // req0 drops after one beat; req3 takes over, then req0 returns.
    do_reset();
    @(negedge clk);
    req_valid = 4'b1001; req_data = 32'h5000_0040;
    #1 expect_out("t4_idle", 4'b0000, 0, 8'h00, 4'b0000, 0);
    @(negedge clk); #1 expect_out("t4_b0", 4'b0001, 1, 8'h40, 4'b0001, 1);
    @(negedge clk);
    req_valid = 4'b1000; req_data = 32'h5000_0000;
    #1 expect_out("t4_drop", 4'b0001, 0, 8'h00, 4'b0001, 1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      req_valid = (k == 3) ? 4'b1001 : 4'b1000;
      req_data  = {8'h50 + 8'(k), 16'h0000, (k == 3) ? 8'h41 : 8'h00};
      #1 expect_out($sformatf("t4_r3b%0d", k), 4'b1000, 1, 8'h50 + 8'(k), 4'b1000, 1);
    end
    @(negedge clk);
    req_valid = 4'b1001; req_data = 32'h5400_0041;
    #1 expect_out("t4_back", 4'b0001, 1, 8'h41, 4'b0001, 1);

    // Reset asserted during req1's third beat.
    do_reset();
    @(negedge clk);
    req_valid = 4'b0010; req_data = 32'h0000_6000;
    #1 expect_out("t5_idle", 4'b0000, 0, 8'h00, 4'b0000, 0);
    @(negedge clk); #1 expect_out("t5_b1", 4'b0010, 1, 8'h60, 4'b0010, 1);
    @(negedge clk); req_data = 32'h0000_6100;
    #1 expect_out("t5_b2", 4'b0010, 1, 8'h61, 4'b0010, 1);
    @(negedge clk); req_data = 32'h0000_6200;
    #1 expect_out("t5_b3", 4'b0010, 1, 8'h62, 4'b0010, 1);
    #1 rst_n = 1'b0;
    #1 expect_out("t5_rst", 4'b0000, 0, 8'h00, 4'b0000, 0);
    @(negedge clk);
    req_valid = 4'b1111; req_data = 32'hA3A2_A1A0;
    #1 expect_out("t5_inrst", 4'b0000, 0, 8'h00, 4'b0000, 0);
    rst_n = 1'b1;
    @(negedge clk); #1 expect_out("t5_first", 4'b0001, 1, 8'hA0, 4'b0001, 1);

    // Two requesters offer 10 words each into the 16-deep FIFO, no reads.
    do_reset();
    use_model = 1'b1;
    i0 = 0; i2 = 0; hs0 = 1'b0; hs2 = 1'b0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      if (hs0) i0++;
      if (hs2) i2++;
      req_valid = {1'b0, i2 < 10, 1'b0, i0 < 10};
      req_data  = {8'h00, 8'h80 + 8'(i2), 8'h00, 8'(i0)};
      #1;
      hs0 = req_valid[0] & req_ready[0];
      hs2 = req_valid[2] & req_ready[2];
    end
    acc = i0 + i2 + int'(hs0) + int'(hs2);
    check("t6_accepted", 32'(acc), 32'd16);
    check("t6_count", 32'(model_count), 32'd16);
    check("t6_fullflag", 32'(model_full), 32'd1);
    check("t6_wr_idle", 32'(fifo_wr_en), 32'd0);
    for (int k = 0; k < 16; k++) begin
      exp_word = ((k / 4) % 2 == 0) ? 8'((k / 8) * 4 + k % 4)
                                     : 8'h80 + 8'((k / 8) * 4 + k % 4);
      check($sformatf("t6_rd%0d", k), 32'(model_mem[k]), 32'(exp_word));
    end
    @(negedge clk);
    req_valid = '0; use_model = 1'b0;

    @(negedge clk); #1;
    check("no_wr_while_full", 32'(viol_cnt), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
